cellrv32_xbus_arbiter: RTL and testbench
========================================

// Module: cellrv32_xbus_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single host port of the Wishbone gateway (XBUS) between
//  port A (DMA / secondary master) and port B (CPU bus switch). Accepts single-cycle rden/wren
//  request pulses on each port, serializes them, replays the winner to the gateway, and routes
//  the ack/err/tmo response back to the owning port. One transfer in flight at the gateway.
// PARAMETERS
//  PRIO_RR     1'b0  0: fixed priority (A beats B); 1: round-robin (last-served port loses tie)
//  STAT_WIDTH  16    width of contention counter (used only with CELLRV32_XBUS_ARB_STAT_EN)
// PORTS
//  clk_i             in   1   global clock, rising edge
//  rst_i             in   1   synchronous reset, active-high
//  {a,b}_src_i       in   1   access type (0 data, 1 instruction)
//  {a,b}_addr_i      in   32  address
//  {a,b}_rden_i      in   1   read request pulse
//  {a,b}_wren_i      in   1   write request pulse
//  {a,b}_ben_i       in   4   byte enable
//  {a,b}_data_i      in   32  write data
//  {a,b}_priv_i      in   1   privilege level
//  {a,b}_data_o      out  32  read data (zero unless own ack)
//  {a,b}_ack_o       out  1   transfer acknowledge pulse
//  {a,b}_err_o       out  1   bus error pulse
//  {a,b}_tmo_o       out  1   bus timeout pulse
//  x_src_o/x_priv_o  out  1   to gateway src_i/priv_i
//  x_addr_o          out  32  to gateway addr_i
//  x_rden_o/x_wren_o out  1   to gateway rden_i/wren_i (one-cycle pulse)
//  x_ben_o           out  4   to gateway ben_i
//  x_data_o          out  32  to gateway data_i
//  x_data_i          in   32  from gateway data_o
//  x_ack_i/x_err_i/x_tmo_i in 1 from gateway ack_o/err_o/tmo_o
//  stat_cont_o       out  STAT_WIDTH  contention count (only with CELLRV32_XBUS_ARB_STAT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pending flags 0, RR pointer -> A favoured.
//  - Request on port p = p_rden_i | p_wren_i; latched (src,addr,we,ben,data,priv) into
//    per-port pending buffer same edge. Each port has max one outstanding request; new pulse
//    while pending/in flight on same port is dropped (protocol violation, no response).
//  - FSM IDLE -> BUSY_A / BUSY_B on edge where a pending (or arriving) request wins;
//    x_rden_o/x_wren_o pulse exactly one cycle, the cycle after grant edge (latency 1 from idle
//    request pulse). x_addr_o/x_ben_o/x_data_o/x_src_o/x_priv_o registered, held stable in BUSY.
//  - BUSY_p: x_ack_i|x_err_i|x_tmo_i routed combinationally to p_ack_o/p_err_o/p_tmo_o, p_data_o
//    = x_data_i on that cycle only; other port sees 0. Same edge: p pending cleared, FSM -> IDLE,
//    or directly BUSY_q if q pending (back-to-back: next x_*en_o pulse on following cycle).
//  - err/tmo terminate identically to ack; precedence when coincident: err > tmo > ack, one
//    response pulse only.
//  - Tie (both pending at grant): PRIO_RR=0 -> A; PRIO_RR=1 -> port not served last.
//  - Request on idle port during other port's BUSY: buffered, never lost, served next.
//  - Responses arriving in IDLE (e.g. after rst_i mid-transfer) are discarded.
//  - rst_i mid-transfer: buffers/FSM cleared next edge; in-flight transfer gets no response.
// CONFIGURATION
//  CELLRV32_XBUS_ARB_STAT_EN defined: stat_cont_o counts cycles with a pending request not
//   granted (either port, +1 per cycle), saturating at all-ones, cleared by rst_i.
//  Undefined: counter not built, stat_cont_o tied to 0.
// TESTING
//  - A read 0x8000_0000 in IDLE -> x_rden_o=1 next cycle, addr 0x8000_0000; x_ack_i w/ data
//    0xDEAD_BEEF 3 cycles later -> a_ack_o=1, a_data_o=0xDEAD_BEEF same cycle, b_* all 0.
//  - A and B write same cycle, PRIO_RR=0 -> A issued first, B issued cycle after A ack; repeat
//    with PRIO_RR=1 after prior A grant -> B first.
//  - B request while A busy, A terminates with x_err_i -> a_err_o=1 only, B issued next cycle
//    with its original addr/ben/data (ben 4'b0011, data 0x1234_5678).
//  - x_err_i and x_ack_i same cycle -> only err_o pulses; x_tmo_i -> tmo_o, FSM to IDLE.
//  - rst_i during BUSY_A, then x_ack_i -> no a_ack_o; all outputs 0 after reset edge.
//  - STAT_EN: B pending 5 cycles behind A -> stat_cont_o=5; force saturation at 16'hFFFF.

Source files
------------

// File: rtl/cellrv32_xbus_arbiter.sv
// cellrv32_xbus_arbiter: serializes two requesters (A, B) onto the single XBUS gateway host port.
// Optional contention counter enabled by defining CELLRV32_XBUS_ARB_STAT_EN.
module cellrv32_xbus_arbiter #(
    parameter logic        PRIO_RR    = 1'b0,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_src_i,
    input  logic [31:0]           a_addr_i,
    input  logic                  a_rden_i,
    input  logic                  a_wren_i,
    input  logic [3:0]            a_ben_i,
    input  logic [31:0]           a_data_i,
    input  logic                  a_priv_i,
    output logic [31:0]           a_data_o,
    output logic                  a_ack_o,
    output logic                  a_err_o,
    output logic                  a_tmo_o,
    input  logic                  b_src_i,
    input  logic [31:0]           b_addr_i,
    input  logic                  b_rden_i,
    input  logic                  b_wren_i,
    input  logic [3:0]            b_ben_i,
    input  logic [31:0]           b_data_i,
    input  logic                  b_priv_i,
    output logic [31:0]           b_data_o,
    output logic                  b_ack_o,
    output logic                  b_err_o,
    output logic                  b_tmo_o,
    output logic                  x_src_o,
    output logic                  x_priv_o,
    output logic [31:0]           x_addr_o,
    output logic                  x_rden_o,
    output logic                  x_wren_o,
    output logic [3:0]            x_ben_o,
    output logic [31:0]           x_data_o,
    input  logic [31:0]           x_data_i,
    input  logic                  x_ack_i,
    input  logic                  x_err_i,
    input  logic                  x_tmo_i,
    output logic [STAT_WIDTH-1:0] stat_cont_o
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY_A, S_BUSY_B} state_t;

    typedef struct packed {
        logic        src;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  ben;
        logic [31:0] data;
        logic        priv;
    } req_t;

    state_t state_q, state_d;
    logic   pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic   last_b_q, last_b_d;
    logic   x_rden_q, x_rden_d, x_wren_q, x_wren_d;
    req_t   buf_a_q, buf_a_d, buf_b_q, buf_b_d, x_req_q, x_req_d;
    req_t   a_req, b_req;
    logic   acc_a, acc_b, resp_any, busy_a, busy_b, free;
    logic   cand_a, cand_b, grant_a, grant_b;
    logic   own_a, own_b;

    // pend_*_q stays set while the request waits and while it is in flight
    always_comb begin
        a_req    = '{src: a_src_i, addr: a_addr_i, we: a_wren_i, ben: a_ben_i,
                     data: a_data_i, priv: a_priv_i};
        b_req    = '{src: b_src_i, addr: b_addr_i, we: b_wren_i, ben: b_ben_i,
                     data: b_data_i, priv: b_priv_i};
        acc_a    = (a_rden_i | a_wren_i) & ~pend_a_q;
        acc_b    = (b_rden_i | b_wren_i) & ~pend_b_q;
        resp_any = x_ack_i | x_err_i | x_tmo_i;
        busy_a   = (state_q == S_BUSY_A);
        busy_b   = (state_q == S_BUSY_B);
        free     = (state_q == S_IDLE) | resp_any;
        cand_a   = free & ~busy_a & (pend_a_q | acc_a);
        cand_b   = free & ~busy_b & (pend_b_q | acc_b);
        grant_a  = cand_a & (~cand_b | ~PRIO_RR | last_b_q);
        grant_b  = cand_b & ~grant_a;
    end

    always_comb begin
        state_d  = state_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        last_b_d = last_b_q;
        buf_a_d  = buf_a_q;
        buf_b_d  = buf_b_q;
        x_req_d  = x_req_q;
        x_rden_d = 1'b0;
        x_wren_d = 1'b0;
        if (acc_a) begin
            pend_a_d = 1'b1;
            buf_a_d  = a_req;
        end
        if (acc_b) begin
            pend_b_d = 1'b1;
            buf_b_d  = b_req;
        end
        if (resp_any && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            if (busy_a) pend_a_d = 1'b0;
            else        pend_b_d = 1'b0;
        end
        if (grant_a) begin
            state_d  = S_BUSY_A;
            last_b_d = 1'b0;
            x_req_d  = pend_a_q ? buf_a_q : a_req;
            x_rden_d = ~x_req_d.we;
            x_wren_d = x_req_d.we;
        end else if (grant_b) begin
            state_d  = S_BUSY_B;
            last_b_d = 1'b1;
            x_req_d  = pend_b_q ? buf_b_q : b_req;
            x_rden_d = ~x_req_d.we;
            x_wren_d = x_req_d.we;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            last_b_q <= 1'b1;
            buf_a_q  <= '0;
            buf_b_q  <= '0;
            x_req_q  <= '0;
            x_rden_q <= 1'b0;
            x_wren_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            last_b_q <= last_b_d;
            buf_a_q  <= buf_a_d;
            buf_b_q  <= buf_b_d;
            x_req_q  <= x_req_d;
            x_rden_q <= x_rden_d;
            x_wren_q <= x_wren_d;
        end
    end

    // Responses are suppressed while reset is asserted so an aborted transfer never completes
    assign own_a    = busy_a & ~rst_i;
    assign own_b    = busy_b & ~rst_i;
    assign a_err_o  = own_a & x_err_i;
    assign a_tmo_o  = own_a & x_tmo_i & ~x_err_i;
    assign a_ack_o  = own_a & x_ack_i & ~x_err_i & ~x_tmo_i;
    assign a_data_o = a_ack_o ? x_data_i : '0;
    assign b_err_o  = own_b & x_err_i;
    assign b_tmo_o  = own_b & x_tmo_i & ~x_err_i;
    assign b_ack_o  = own_b & x_ack_i & ~x_err_i & ~x_tmo_i;
    assign b_data_o = b_ack_o ? x_data_i : '0;

    assign x_src_o  = x_req_q.src;
    assign x_priv_o = x_req_q.priv;
    assign x_addr_o = x_req_q.addr;
    assign x_ben_o  = x_req_q.ben;
    assign x_data_o = x_req_q.data;
    assign x_rden_o = x_rden_q;
    assign x_wren_o = x_wren_q;

`ifdef CELLRV32_XBUS_ARB_STAT_EN
    logic [STAT_WIDTH-1:0] stat_q, stat_d;
    logic                  wait_a, wait_b;

    always_comb begin
        wait_a = pend_a_q & ~busy_a & ~grant_a;
        wait_b = pend_b_q & ~busy_b & ~grant_b;
        stat_d = stat_q;
        if ((wait_a | wait_b) && (stat_q != '1)) begin
            stat_d = stat_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_cont_o = stat_q;
`else
    assign stat_cont_o = '0;
`endif

endmodule

// File: tb/tb_cellrv32_xbus_arbiter.sv
// Randomized scoreboard bench: fixed-priority and round-robin instances share the A/B request stimulus.
module tb_cellrv32_xbus_arbiter;
    localparam int SW = 6;

    typedef struct packed {
        logic        src;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  ben;
        logic [31:0] data;
        logic        priv;
    } req_t;

    typedef struct {
        req_t r;
        int   cyc;
    } iss_t;

    typedef struct {
        int          port;
        int          kind;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_src = 1'b0, a_rden = 1'b0, a_wren = 1'b0, a_priv = 1'b0;
    logic b_src = 1'b0, b_rden = 1'b0, b_wren = 1'b0, b_priv = 1'b0;
    logic [31:0] a_addr = '0, a_data = '0, b_addr = '0, b_data = '0;
    logic [3:0]  a_ben = '0, b_ben = '0;

    logic [31:0]   a_rd[2], b_rd[2], x_addr[2], x_wdata[2], x_rdata[2];
    logic          a_ack[2], a_err[2], a_tmo[2], b_ack[2], b_err[2], b_tmo[2];
    logic          x_src[2], x_priv[2], x_rden[2], x_wren[2];
    logic          x_ack[2], x_err[2], x_tmo[2];
    logic [3:0]    x_ben[2];
    logic [SW-1:0] stat[2];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rst_was = 1'b1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cellrv32_xbus_arbiter #(.PRIO_RR(g == 1), .STAT_WIDTH(SW)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .a_src_i(a_src), .a_addr_i(a_addr), .a_rden_i(a_rden), .a_wren_i(a_wren),
            .a_ben_i(a_ben), .a_data_i(a_data), .a_priv_i(a_priv),
            .a_data_o(a_rd[g]), .a_ack_o(a_ack[g]), .a_err_o(a_err[g]), .a_tmo_o(a_tmo[g]),
            .b_src_i(b_src), .b_addr_i(b_addr), .b_rden_i(b_rden), .b_wren_i(b_wren),
            .b_ben_i(b_ben), .b_data_i(b_data), .b_priv_i(b_priv),
            .b_data_o(b_rd[g]), .b_ack_o(b_ack[g]), .b_err_o(b_err[g]), .b_tmo_o(b_tmo[g]),
            .x_src_o(x_src[g]), .x_priv_o(x_priv[g]), .x_addr_o(x_addr[g]),
            .x_rden_o(x_rden[g]), .x_wren_o(x_wren[g]), .x_ben_o(x_ben[g]),
            .x_data_o(x_wdata[g]), .x_data_i(x_rdata[g]),
            .x_ack_i(x_ack[g]), .x_err_i(x_err[g]), .x_tmo_i(x_tmo[g]),
            .stat_cont_o(stat[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_was <= rst;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: actual %h required %h", nm, cyc, got, exp);
        end
    endtask

    task automatic flag(input string nm, input string what);
        tests++;
        fails++;
        $display("FAIL %s @cyc %0d: actual %s", nm, cyc, what);
    endtask

    // Gateway model: answers each issued transfer after 1..4 cycles, plus rare stray responses
    int cnt[2] = '{0, 0};
    int k;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            x_ack[i]   = 1'b0;
            x_err[i]   = 1'b0;
            x_tmo[i]   = 1'b0;
            x_rdata[i] = $urandom;
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    k = $urandom_range(0, 9);
                    x_ack[i] = (k < 6) || (k >= 8);
                    x_err[i] = (k == 6) || (k == 8);
                    x_tmo[i] = (k == 7) || (k == 9);
                end
            end else if ($urandom_range(0, 59) == 0) begin
                x_ack[i] = 1'b1;
            end
            if (x_rden[i] | x_wren[i]) cnt[i] = $urandom_range(1, 4);
        end
    end

    // Reference model: transaction-level bookkeeping of outstanding requests per port
    req_t m_buf[2][2];
    bit   m_pend[2][2];
    int   m_own[2]  = '{-1, -1};
    int   m_last[2] = '{1, 1};
    int   m_stat[2] = '{0, 0};
    int   m_stat_show[2] = '{0, 0};
    iss_t iq[2][$];
    rsp_t rq[2][$];
    req_t rin[2];
    bit   rreq[2], oldp[2], waiting;
    int   oldown, g, kind;

    always @(negedge clk) begin
        rin[0]  = '{a_src, a_addr, a_wren, a_ben, a_data, a_priv};
        rin[1]  = '{b_src, b_addr, b_wren, b_ben, b_data, b_priv};
        rreq[0] = a_rden | a_wren;
        rreq[1] = b_rden | b_wren;
        for (int i = 0; i < 2; i++) begin
            m_stat_show[i] = m_stat[i];
            if (rst) begin
                m_pend[i][0] = 1'b0;
                m_pend[i][1] = 1'b0;
                m_own[i]     = -1;
                m_last[i]    = 1;
                m_stat[i]    = 0;
            end else begin
                oldp[0] = m_pend[i][0];
                oldp[1] = m_pend[i][1];
                oldown  = m_own[i];
                for (int p = 0; p < 2; p++) begin
                    if (rreq[p] && !m_pend[i][p]) begin
                        m_pend[i][p] = 1'b1;
                        m_buf[i][p]  = rin[p];
                    end
                end
                if (m_own[i] >= 0 && (x_ack[i] || x_err[i] || x_tmo[i])) begin
                    kind = x_err[i] ? 2 : (x_tmo[i] ? 3 : 1);
                    rq[i].push_back('{port: m_own[i], kind: kind,
                                      data: (kind == 1) ? x_rdata[i] : 32'h0, cyc: cyc});
                    m_pend[i][m_own[i]] = 1'b0;
                    m_own[i] = -1;
                end
                g = -1;
                if (m_own[i] < 0) begin
                    if (m_pend[i][0] && m_pend[i][1]) g = (i == 1) ? 1 - m_last[i] : 0;
                    else if (m_pend[i][0])            g = 0;
                    else if (m_pend[i][1])            g = 1;
                end
                if (g >= 0) begin
                    m_own[i]  = g;
                    m_last[i] = g;
                    iq[i].push_back('{r: m_buf[i][g], cyc: cyc + 1});
                end
                waiting = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (oldp[p] && p != oldown && p != g) waiting = 1'b1;
                end
                if (waiting && m_stat[i] < (1 << SW) - 1) m_stat[i]++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows an issue pulse or a port response
    iss_t it;
    rsp_t rt;
    logic [69:0] got_r, exp_r;
    int   exp_stat;

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
`ifdef CELLRV32_XBUS_ARB_STAT_EN
            exp_stat = m_stat_show[i];
`else
            exp_stat = 0;
`endif
            chk($sformatf("stat%0d", i), 128'(stat[i]), 128'(exp_stat));
            if (rst_was) begin
                chk($sformatf("rst_x%0d", i),
                    128'({x_rden[i], x_wren[i], x_src[i], x_addr[i], x_ben[i], x_wdata[i], x_priv[i]}),
                    128'(0));
                chk($sformatf("rst_rsp%0d", i),
                    128'({a_ack[i], a_err[i], a_tmo[i], b_ack[i], b_err[i], b_tmo[i], a_rd[i], b_rd[i]}),
                    128'(0));
            end
            if (x_rden[i] | x_wren[i]) begin
                if (iq[i].size() == 0) begin
                    flag($sformatf("issue%0d", i), "unexpected gateway pulse, required none");
                end else begin
                    it = iq[i].pop_front();
                    chk($sformatf("issue_cyc%0d", i), 128'(cyc), 128'(it.cyc));
                    chk($sformatf("issue%0d", i),
                        128'({x_rden[i], x_wren[i], x_src[i], x_addr[i], x_ben[i], x_wdata[i], x_priv[i]}),
                        128'({~it.r.we, it.r.we, it.r.src, it.r.addr, it.r.ben, it.r.data, it.r.priv}));
                end
            end
            while (iq[i].size() > 0 && iq[i][0].cyc < cyc) begin
                it = iq[i].pop_front();
                flag($sformatf("issue_late%0d", i), $sformatf("no pulse, required one at cyc %0d", it.cyc));
            end
            got_r = {a_ack[i], a_err[i], a_tmo[i], b_ack[i], b_err[i], b_tmo[i], a_rd[i], b_rd[i]};
            if (got_r != '0) begin
                if (rq[i].size() == 0) begin
                    flag($sformatf("rsp%0d", i), $sformatf("unexpected response %h, required none", got_r));
                end else begin
                    rt = rq[i].pop_front();
                    exp_r = {rt.port == 0 && rt.kind == 1, rt.port == 0 && rt.kind == 2,
                             rt.port == 0 && rt.kind == 3, rt.port == 1 && rt.kind == 1,
                             rt.port == 1 && rt.kind == 2, rt.port == 1 && rt.kind == 3,
                             (rt.port == 0) ? rt.data : 32'h0, (rt.port == 1) ? rt.data : 32'h0};
                    chk($sformatf("rsp_cyc%0d", i), 128'(cyc), 128'(rt.cyc));
                    chk($sformatf("rsp%0d", i), 128'(got_r), 128'(exp_r));
                end
            end
            while (rq[i].size() > 0 && rq[i][0].cyc < cyc) begin
                rt = rq[i].pop_front();
                flag($sformatf("rsp_late%0d", i), $sformatf("no response, required one at cyc %0d", rt.cyc));
            end
        end
    end

    // Stimulus: single-cycle request pulses with fresh random attributes every cycle
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst    = ($urandom_range(0, 299) == 0);
            a_src  = 1'($urandom);
            a_priv = 1'($urandom);
            a_addr = $urandom;
            a_data = $urandom;
            a_ben  = 4'($urandom);
            b_src  = 1'($urandom);
            b_priv = 1'($urandom);
            b_addr = $urandom;
            b_data = $urandom;
            b_ben  = 4'($urandom);
            a_rden = 1'b0;
            a_wren = 1'b0;
            b_rden = 1'b0;
            b_wren = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) a_wren = 1'b1;
                else                           a_rden = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) b_wren = 1'b1;
                else                           b_rden = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        a_rden = 1'b0;
        a_wren = 1'b0;
        b_rden = 1'b0;
        b_wren = 1'b0;
        repeat (40) @(posedge clk);
        #8;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("issue_drain%0d", i), 128'(iq[i].size()), 128'(0));
            chk($sformatf("rsp_drain%0d", i), 128'(rq[i].size()), 128'(0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
